lz77_job_scheduler: RTL and testbench
=====================================

// Module: lz77_job_scheduler
// PURPOSE
//  Shares one lz77_compressor instance between NUM_REQ byte-stream requesters, one job at a time.
//  Round-robin picks a requester, clears and starts the compressor, and routes that requester's bytes in.
//  Returns the compressed bit stream tagged with the job owner, then reports job completion and byte count.
//  Sits between the requester DMA/stream ports and the compressor core.
// PARAMETERS
//  NUM_REQ       4  number of requesters (2..8)
//  ID_BITS       2  width of requester id, = clog2(NUM_REQ)
//  CLEAR_CYCLES  2  cycles cmp_rst_n is held low before each job (>=1)
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous reset, active-high
//  req_valid      in   NUM_REQ    per-requester byte valid
//  req_data       in   8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
//  req_last       in   NUM_REQ    qualifies the final byte of the job
//  req_ready      out  NUM_REQ    byte accepted when req_valid[i] && req_ready[i]
//  cmp_rst_n      out  1          compressor reset, active-low
//  cmp_start      out  1          compressor start pulse
//  cmp_busy       in   1          compressor busy
//  cmp_done       in   1          compressor done (sticky until cmp_rst_n)
//  cmp_in_data    out  8          compressor inputData
//  cmp_in_valid   out  1          compressor inputValid
//  cmp_in_ready   in   1          compressor inputReady
//  cmp_in_last    out  1          compressor lastInputPassed
//  cmp_out_bit    in   1          compressor outputBit
//  cmp_out_valid  in   1          compressor outputValid
//  cmp_out_ready  out  1          compressor outputReady
//  cmp_bytes      in   32         compressor bytesRead
//  out_bit        out  1          compressed bit to downstream
//  out_valid      out  1          bit valid
//  out_ready      in   1          downstream ready
//  out_id         out  ID_BITS    owner of the current job
//  job_done       out  1          one-cycle pulse at job end
//  job_id         out  ID_BITS    owner of the finished job, valid with job_done
//  job_bytes      out  32         input bytes consumed, latched from cmp_bytes, valid with job_done
// BEHAVIOUR
//  Reset values:
//   state=IDLE; rr pointer=0; cmp_rst_n=0; cmp_start=0; job_done=0.
//   req_ready=0; cmp_in_valid=0; cmp_out_ready=0; out_valid=0.
//   out_id, job_id, job_bytes = 0.
//  Reset mid-job drops the job silently. The compressor is held in reset while rst=1.
//  IDLE:
//   cmp_rst_n=1. If any req_valid is set, grant the first set bit at or after the rr pointer, wrapping modulo NUM_REQ.
//   Latch grant into out_id, then go to CLEAR. No byte is consumed in IDLE.
//  CLEAR: cmp_rst_n=0 for exactly CLEAR_CYCLES cycles, then go to START.
//  START:
//   cmp_rst_n=1 and cmp_start=1 for one cycle, then go to RUN.
//   Total grant-to-start latency = CLEAR_CYCLES+1.
//  RUN: combinational pass-through for the granted requester g only.
//   cmp_in_data = req_data[g]; cmp_in_valid = req_valid[g]; cmp_in_last = req_last[g]; req_ready[g] = cmp_in_ready.
//   All other req_ready bits are 0.
//   out_bit = cmp_out_bit; out_valid = cmp_out_valid; cmp_out_ready = out_ready.
//   An accepted byte with req_last set sets the internal last_seen flag.
//   Requester stalls (valid=0) are legal. Bytes after last_seen are not accepted.
//   When cmp_done=1: latch job_bytes=cmp_bytes and go to REPORT.
//  REPORT:
//   job_done=1 for one cycle, job_id=out_id.
//   rr pointer = (g+1) mod NUM_REQ.
//   Go to IDLE. The compressor stays done until the next CLEAR.
//  Boundaries:
//   Simultaneous requests are served strictly round-robin. A lone requester may be granted back-to-back.
//   A 1-byte job (req_last on the first byte) is legal.
//   out_valid is never asserted outside RUN.
//   cmp_done seen with last_seen=0 is a protocol error: report the job anyway.
//   A requester dropping req_valid while not granted loses nothing, because no byte was consumed.
// STRUCTURE
//  lz77_pkg:
//   state encoding (IDLE/CLEAR/START/RUN/REPORT).
//   token widths (literal 9 bits, match 19 bits).
//   MIN_MATCH = 3.
//  Sub-module rr_arbiter:
//   inputs: request vector, pointer.
//   output: one-hot grant + index; combinational.
//  Top level holds the FSM, CLEAR counter, grant/id registers and the muxes.
// TESTING
//  - Single job, req 0 sends "ABCABCABC" with last on byte 9 -> cmp_start 3 cycles after grant; job_done with job_id=0, job_bytes=9; bit stream matches the model.
//  - req 1 and req 3 valid together, pointer=0 -> req 1 served first, then req 3; out_id tracks each job; req_ready[3]=0 throughout job 1.
//  - Downstream out_ready toggles 1/0 every cycle -> no bit lost or duplicated; stream equals the out_ready=1 reference.
//  - Repeated requests from req 2 only -> back-to-back jobs; second job_bytes counts only its own bytes (compressor was cleared).
//  - rst=1 asserted mid-RUN -> next cycle req_ready=0, out_valid=0, cmp_rst_n=0; after release, a fresh job completes normally.
//  - 1-byte job (0x41, last) -> job_bytes=1; 9-bit literal 1_01000001 emitted.

Source files
------------

// File: rtl/lz77_job_scheduler_pkg.sv
// Shared types for the LZ77 job scheduler: FSM encoding, token sizes and small helpers.
// Pure declarations; no timing or flow-control behaviour of its own.
package lz77_job_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_START,
    ST_RUN,
    ST_REPORT
  } state_e;

  localparam int LIT_TOKEN_BITS   = 9;
  localparam int MATCH_TOKEN_BITS = 19;
  localparam int MIN_MATCH        = 3;

  function automatic int token_bits(input logic is_match);
    return is_match ? MATCH_TOKEN_BITS : LIT_TOKEN_BITS;
  endfunction

  function automatic logic match_worthwhile(input int len);
    return len >= MIN_MATCH;
  endfunction

  // Increment modulo n, safe for n that is not a power of two.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/lz77_job_scheduler_rr_arbiter.sv
// Round-robin pick of the first request at or after ptr_i, wrapping modulo N.
// Purely combinational, zero latency; no backpressure of its own.
module lz77_job_scheduler_rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDW'((int'(ptr_i) + k) % N);
      if (!found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        found       = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/lz77_job_scheduler.sv
// Time-shares one LZ77 compressor among NUM_REQ byte streams, one job at a time, round-robin.
// Grant-to-start CLEAR_CYCLES+1 cycles; in RUN ready/valid pass straight through for the owner only.
module lz77_job_scheduler
  import lz77_job_scheduler_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ID_BITS      = 2,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   cmp_rst_n_o,
  output logic                   cmp_start_o,
  input  logic                   cmp_busy_i,
  input  logic                   cmp_done_i,
  output logic [7:0]             cmp_in_data_o,
  output logic                   cmp_in_valid_o,
  input  logic                   cmp_in_ready_i,
  output logic                   cmp_in_last_o,
  input  logic                   cmp_out_bit_i,
  input  logic                   cmp_out_valid_i,
  output logic                   cmp_out_ready_o,
  input  logic [31:0]            cmp_bytes_i,
  output logic                   out_bit_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [ID_BITS-1:0]     out_id_o,
  output logic                   job_done_o,
  output logic [ID_BITS-1:0]     job_id_o,
  output logic [31:0]            job_bytes_o
);

  localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  state_e               state_q, state_d;
  logic [CW-1:0]        clr_cnt_q, clr_cnt_d;
  logic [ID_BITS-1:0]   rr_q, rr_d;
  logic [ID_BITS-1:0]   id_q, id_d;
  logic [ID_BITS-1:0]   job_id_q, job_id_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 last_seen_q, last_seen_d;
  logic [31:0]          job_bytes_q, job_bytes_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [ID_BITS-1:0]   arb_idx;
  logic                 arb_any;
  logic [7:0]           sel_data;
  logic                 sel_valid, sel_last, byte_acc;
  logic                 busy_unused;

  // Busy is implied by the FSM phase; done alone ends the job.
  assign busy_unused = cmp_busy_i;

  lz77_job_scheduler_rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (ID_BITS)
  ) u_arb (
    .req_i (req_valid_i),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign sel_data  = req_data_i[{id_q, 3'b000} +: 8];
  assign sel_valid = req_valid_i[id_q];
  assign sel_last  = req_last_i[id_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      rr_q        <= '0;
      id_q        <= '0;
      job_id_q    <= '0;
      gnt_q       <= '0;
      last_seen_q <= 1'b0;
      job_bytes_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      job_id_q    <= job_id_d;
      gnt_q       <= gnt_d;
      last_seen_q <= last_seen_d;
      job_bytes_q <= job_bytes_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    clr_cnt_d       = clr_cnt_q;
    rr_d            = rr_q;
    id_d            = id_q;
    job_id_d        = job_id_q;
    gnt_d           = gnt_q;
    last_seen_d     = last_seen_q;
    job_bytes_d     = job_bytes_q;

    req_ready_o     = '0;
    cmp_start_o     = 1'b0;
    cmp_in_data_o   = '0;
    cmp_in_valid_o  = 1'b0;
    cmp_in_last_o   = 1'b0;
    cmp_out_ready_o = 1'b0;
    out_bit_o       = 1'b0;
    out_valid_o     = 1'b0;
    job_done_o      = 1'b0;
    byte_acc        = 1'b0;
    // The compressor follows our own reset so an aborted job leaves nothing behind.
    cmp_rst_n_o     = ~rst_i;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          id_d        = arb_idx;
          gnt_d       = arb_gnt;
          clr_cnt_d   = '0;
          last_seen_d = 1'b0;
          state_d     = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cmp_rst_n_o = 1'b0;
        if (clr_cnt_q == CW'(CLEAR_CYCLES - 1)) begin
          state_d = ST_START;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ST_START: begin
        cmp_start_o = 1'b1;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        // Once the last byte is in, the owner's next job must wait for a new grant.
        cmp_in_data_o   = sel_data;
        cmp_in_valid_o  = sel_valid & ~last_seen_q;
        cmp_in_last_o   = sel_last;
        req_ready_o     = (cmp_in_ready_i & ~last_seen_q) ? gnt_q : '0;
        byte_acc        = sel_valid & cmp_in_ready_i & ~last_seen_q;
        out_bit_o       = cmp_out_bit_i;
        out_valid_o     = cmp_out_valid_i;
        cmp_out_ready_o = out_ready_i;
        if (byte_acc && sel_last) begin
          last_seen_d = 1'b1;
        end
        if (cmp_done_i) begin
          job_bytes_d = cmp_bytes_i;
          job_id_d    = id_q;
          state_d     = ST_REPORT;
        end
      end
      ST_REPORT: begin
        job_done_o = 1'b1;
        rr_d       = ID_BITS'(wrap_inc(int'(id_q), NUM_REQ));
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_id_o    = id_q;
  assign job_id_o    = job_id_q;
  assign job_bytes_o = job_bytes_q;

endmodule

// File: tb/tb_lz77_job_scheduler.sv
// Bench: literal-only compressor stand-in, per-requester byte streams, and a round-robin job-order model.
module tb_lz77_job_scheduler;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_last, req_ready;
  logic [8*N-1:0]   req_data;
  logic             cmp_rst_n, cmp_start, cmp_busy, cmp_done;
  logic [7:0]       cmp_in_data;
  logic             cmp_in_valid, cmp_in_ready, cmp_in_last;
  logic             cmp_out_bit, cmp_out_valid, cmp_out_ready;
  logic [31:0]      cmp_bytes;
  logic             out_bit, out_valid, out_ready;
  logic [1:0]       out_id, job_id;
  logic             job_done;
  logic [31:0]      job_bytes;

  always #5 clk = ~clk;

  lz77_job_scheduler #(.NUM_REQ(N), .ID_BITS(2), .CLEAR_CYCLES(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last), .req_ready_o(req_ready),
    .cmp_rst_n_o(cmp_rst_n), .cmp_start_o(cmp_start), .cmp_busy_i(cmp_busy), .cmp_done_i(cmp_done),
    .cmp_in_data_o(cmp_in_data), .cmp_in_valid_o(cmp_in_valid), .cmp_in_ready_i(cmp_in_ready),
    .cmp_in_last_o(cmp_in_last), .cmp_out_bit_i(cmp_out_bit), .cmp_out_valid_i(cmp_out_valid),
    .cmp_out_ready_o(cmp_out_ready), .cmp_bytes_i(cmp_bytes),
    .out_bit_o(out_bit), .out_valid_o(out_valid), .out_ready_i(out_ready), .out_id_o(out_id),
    .job_done_o(job_done), .job_id_o(job_id), .job_bytes_o(job_bytes)
  );

  int checks = 0;
  int failures = 0;

  // requester streams
  byte unsigned sbyte[N][$];
  bit           slast[N][$];
  bit           started[N];
  byte unsigned stage[$];
  byte unsigned saved[N][$];

  // scoreboard
  bit           exp_bits[$];
  int           exp_id[$];
  int           exp_len[$];
  int           job_bits = 0;
  logic [8:0]   last9 = '0;
  int           ready_leaks = 0;
  int           model_ptr = 0;

  // stimulus knobs
  int out_mode = 0;
  bit stall_en = 0;
  bit inrdy_rand = 0;
  bit tgl = 0;

  // compressor stand-in
  bit f_busy, f_done, f_last, f_in_ready;
  int f_bytes;
  bit f_bits[$];

  // handshakes sampled at the falling edge
  logic [N-1:0] s_acc;
  bit           s_in_acc, s_in_last, s_cout_acc, s_start, s_rst_n;
  logic [7:0]   s_in_byte;

  typedef struct {
    logic [3:0] mask;
    int         n;
    logic [7:0] order;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (sbyte[i].size() > 0) begin
        req_valid[i]      = !(stall_en && started[i] && $urandom_range(0, 3) == 0);
        req_data[8*i +: 8] = sbyte[i][0];
        req_last[i]       = slast[i][0];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
    case (out_mode)
      0:       out_ready = 1'b1;
      1:       begin out_ready = tgl; tgl = ~tgl; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic sample();
    s_acc      = req_valid & req_ready;
    s_in_acc   = cmp_in_valid && cmp_in_ready;
    s_in_byte  = cmp_in_data;
    s_in_last  = cmp_in_last;
    s_cout_acc = cmp_out_valid && cmp_out_ready;
    s_start    = cmp_start;
    s_rst_n    = cmp_rst_n;
    if (out_valid && out_ready) begin
      if (exp_bits.size() == 0) begin
        checks++; failures++;
        $display("FAIL stray_bit: got bit %0b expected no bit", out_bit);
      end else begin
        chk("out_bit", 32'(out_bit), 32'(exp_bits.pop_front()));
        chk("out_id", 32'(out_id), 32'(exp_id[0]));
      end
      last9 = {last9[7:0], out_bit};
      job_bits++;
    end
    if (job_done) begin
      if (exp_id.size() == 0) begin
        checks++; failures++;
        $display("FAIL stray_job: got job_id %0d expected no job", job_id);
      end else begin
        chk("job_id", 32'(job_id), 32'(exp_id[0]));
        chk("job_bytes", job_bytes, 32'(exp_len[0]));
        chk("job_bits", 32'(job_bits), 32'(9 * exp_len[0]));
        void'(exp_id.pop_front());
        void'(exp_len.pop_front());
      end
      job_bits = 0;
    end
    for (int i = 0; i < N; i++)
      if (req_ready[i] && i != int'(out_id)) ready_leaks++;
  endtask

  task automatic update_models();
    for (int i = 0; i < N; i++) begin
      if (s_acc[i]) begin
        started[i] = !slast[i][0];
        void'(sbyte[i].pop_front());
        void'(slast[i].pop_front());
      end
    end
    if (!s_rst_n) begin
      f_busy = 0; f_done = 0; f_last = 0; f_bytes = 0;
      f_bits.delete();
    end else begin
      if (s_start) begin
        f_busy = 1; f_done = 0; f_last = 0; f_bytes = 0;
      end
      if (s_cout_acc) void'(f_bits.pop_front());
      if (s_in_acc) begin
        f_bytes++;
        f_bits.push_back(1'b1);
        for (int b = 7; b >= 0; b--) f_bits.push_back(s_in_byte[b]);
        if (s_in_last) f_last = 1;
      end
      if (f_busy && f_last && f_bits.size() == 0) begin
        f_busy = 0; f_done = 1;
      end
    end
    f_in_ready    = f_busy && !f_last && (!inrdy_rand || $urandom_range(0, 2) != 0);
    cmp_busy      = f_busy;
    cmp_done      = f_done;
    cmp_bytes     = 32'(f_bytes);
    cmp_in_ready  = f_in_ready;
    cmp_out_valid = f_bits.size() > 0;
    cmp_out_bit   = (f_bits.size() > 0) ? f_bits[0] : 1'b0;
  endtask

  task automatic tick();
    drive_inputs();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    update_models();
  endtask

  task automatic push_stream(input int id);
    for (int k = 0; k < stage.size(); k++) begin
      sbyte[id].push_back(stage[k]);
      slast[id].push_back(k == stage.size() - 1);
    end
  endtask

  // Expected output of one job: each byte becomes the literal token 1_bbbbbbbb.
  task automatic push_expect(input int id);
    exp_id.push_back(id);
    exp_len.push_back(stage.size());
    for (int k = 0; k < stage.size(); k++) begin
      exp_bits.push_back(1'b1);
      for (int b = 7; b >= 0; b--) exp_bits.push_back(stage[k][b]);
    end
  endtask

  task automatic add_job(input int id);
    push_stream(id);
    push_expect(id);
  endtask

  task automatic fill_random(input int len);
    stage.delete();
    for (int k = 0; k < len; k++) stage.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic fill_abc();
    stage.delete();
    for (int k = 0; k < 9; k++) stage.push_back(8'(8'h41 + k % 3));
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      sbyte[i].delete(); slast[i].delete(); started[i] = 0;
    end
    exp_bits.delete(); exp_id.delete(); exp_len.delete();
    job_bits = 0;
  endtask

  task automatic run_jobs(input string name, input int max_cycles);
    int n = 0;
    while (exp_id.size() > 0 && n < max_cycles) begin
      tick();
      n++;
    end
    if (exp_id.size() > 0) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got %0d jobs outstanding expected 0", name, exp_id.size());
      flush();
    end
    chk({name, "_bits_left"}, 32'(exp_bits.size()), 32'd0);
    chk({name, "_ready_leak"}, 32'(ready_leaks), 32'd0);
    repeat (2) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    flush();
    model_ptr = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int start_at;
    int cnt;
    int id;
    int pool_len[N][$];
    byte unsigned pool_bytes[N][$];

    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b1;
    cmp_busy = 0; cmp_done = 0; cmp_bytes = '0; cmp_in_ready = 0;
    cmp_out_bit = 0; cmp_out_valid = 0;
    f_busy = 0; f_done = 0; f_last = 0; f_in_ready = 0; f_bytes = 0;
    for (int i = 0; i < N; i++) started[i] = 0;

    repeat (2) tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_cmp_in_valid", 32'(cmp_in_valid), 32'd0);
    chk("rst_cmp_out_ready", 32'(cmp_out_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cmp_rst_n", 32'(cmp_rst_n), 32'd0);
    chk("rst_cmp_start", 32'(cmp_start), 32'd0);
    chk("rst_job_done", 32'(job_done), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_job_id", 32'(job_id), 32'd0);
    chk("rst_job_bytes", job_bytes, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_cmp_rst_n", 32'(cmp_rst_n), 32'd1);

    // Single "ABCABCABC" job from requester 0, with grant-to-start latency.
    fill_abc();
    add_job(0);
    start_at = -1;
    for (int n = 0; n < 10 && start_at < 0; n++) begin
      tick();
      if (s_start) start_at = n;
    end
    chk("grant_to_start", 32'(start_at), 32'd3);
    run_jobs("abc", 500);

    // One-byte job.
    stage.delete();
    stage.push_back(8'h41);
    add_job(0);
    run_jobs("one_byte", 200);
    chk("one_byte_literal", 32'(last9), 32'h141);

    // Reset in the middle of a job, then a fresh job.
    fill_random(20);
    add_job(2);
    cnt = 0;
    while (sbyte[2].size() > 16 && cnt < 80) begin tick(); cnt++; end
    chk("rst_mid_reached_run", 32'(sbyte[2].size() <= 16), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_cmp_rst_n", 32'(cmp_rst_n), 32'd0);
    tick();
    rst = 1'b0;
    flush();
    fill_random(5);
    add_job(2);
    run_jobs("after_rst", 400);

    // Downstream ready toggling every cycle.
    out_mode = 1;
    fill_abc();
    add_job(1);
    run_jobs("toggle", 800);
    out_mode = 0;

    // Back-to-back jobs from a lone requester.
    fill_random(4);
    add_job(2);
    fill_random(7);
    add_job(2);
    run_jobs("b2b", 800);

    // Arbitration table: requesters in mask raise one job each, expected service order.
    tbl[0] = '{mask: 4'b1010, n: 2, order: 8'h0D};
    tbl[1] = '{mask: 4'b1111, n: 4, order: 8'hE4};
    tbl[2] = '{mask: 4'b0100, n: 1, order: 8'h02};
    tbl[3] = '{mask: 4'b0100, n: 1, order: 8'h02};
    tbl[4] = '{mask: 4'b0101, n: 2, order: 8'h08};
    tbl[5] = '{mask: 4'b1001, n: 2, order: 8'h03};
    tbl[6] = '{mask: 4'b0011, n: 2, order: 8'h01};
    do_reset();
    for (int e = 0; e < 7; e++) begin
      for (int i = 0; i < N; i++) begin
        if (tbl[e].mask[i]) begin
          fill_random(int'($urandom_range(1, 5)));
          push_stream(i);
          saved[i] = stage;
        end
      end
      for (int k = 0; k < tbl[e].n; k++) begin
        id = int'(tbl[e].order[2*k +: 2]);
        stage = saved[id];
        push_expect(id);
        model_ptr = (id + 1) % N;
      end
      run_jobs("table", 800);
    end

    // Randomized rounds with stalls everywhere; order from a round-robin model.
    stall_en = 1; inrdy_rand = 1; out_mode = 2;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        cnt = int'($urandom_range(0, 2));
        for (int j = 0; j < cnt; j++) begin
          fill_random(int'($urandom_range(1, 8)));
          push_stream(i);
          pool_len[i].push_back(stage.size());
          for (int k = 0; k < stage.size(); k++) pool_bytes[i].push_back(stage[k]);
        end
      end
      forever begin
        id = -1;
        for (int k = 0; k < N && id < 0; k++)
          if (pool_len[(model_ptr + k) % N].size() > 0) id = (model_ptr + k) % N;
        if (id < 0) break;
        cnt = pool_len[id].pop_front();
        stage.delete();
        for (int k = 0; k < cnt; k++) stage.push_back(pool_bytes[id].pop_front());
        push_expect(id);
        model_ptr = (id + 1) % N;
      end
      run_jobs("random", 6000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
